servile_timer: RTL and testbench

RISC-V machine timer peripheral attached to the servile extension Wishbone port. It provides a 64-bit free-running `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register, and a level timer interrupt that drives the servile `i_timer_irq` input. Software reads and writes all registers through single-access Wishbone transfers.

---
 rtl/servile_timer.sv | 140 ++++++++++++++
 tb/tb_servile_timer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/servile_timer.sv
// servile_timer: RISC-V machine timer on a single-access Wishbone slave port.
// 64-bit mtime with a programmable prescaler, 64-bit mtimecmp, level interrupt.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_wb_adr[2:0]         word address (0 mtime_lo, 1 mtime_hi/shadow,
//                         2 mtimecmp_lo, 3 mtimecmp_hi, 4 prescale, 5-7 unused)
//   i_wb_dat, i_wb_sel    write data and byte enables
//   i_wb_we, i_wb_stb     write strobe and transfer request
//   o_wb_rdt, o_wb_ack    read data and single-cycle acknowledge
//   o_irq                 timer interrupt level (mtime >= mtimecmp)
module servile_timer #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_wb_adr,
  input  logic [31:0]           i_wb_dat,
  input  logic [3:0]            i_wb_sel,
  input  logic                  i_wb_we,
  input  logic                  i_wb_stb,
  output logic [31:0]           o_wb_rdt,
  output logic                  o_wb_ack,
  output logic                  o_irq
);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_PRESCALE = 3'd4;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pcnt;
  logic [31:0]           shadow;

  logic                  access_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  tick_c;
  logic [63:0]           mtime_nxt_c;
  logic [31:0]           rdt_c;

  // Byte-lane merge of write data over the current register contents.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  // A transfer is taken only on the edge where ack rises.
  assign access_c = i_wb_stb & ~o_wb_ack;
  assign wr_c     = access_c & i_wb_we;
  assign rd_c     = access_c & ~i_wb_we;
  assign tick_c   = (pcnt == prescale);

  // mtime next value: a write to either half beats the tick.
  always_comb begin
    mtime_nxt_c = mtime;
    if (tick_c) begin
      mtime_nxt_c = mtime + 64'd1;
    end
    if (wr_c && i_wb_adr == ADR_MTIME_LO) begin
      mtime_nxt_c = {mtime[63:32], lane_merge(mtime[31:0], i_wb_dat, i_wb_sel)};
    end else if (wr_c && i_wb_adr == ADR_MTIME_HI) begin
      mtime_nxt_c = {lane_merge(mtime[63:32], i_wb_dat, i_wb_sel), mtime[31:0]};
    end
  end

  // Read mux; the high half of mtime reads the shadow captured by the low read.
  always_comb begin
    rdt_c = 32'd0;
    case (i_wb_adr)
      ADR_MTIME_LO: rdt_c = mtime[31:0];
      ADR_MTIME_HI: rdt_c = shadow;
      ADR_CMP_LO:   rdt_c = mtimecmp[31:0];
      ADR_CMP_HI:   rdt_c = mtimecmp[63:32];
      ADR_PRESCALE: rdt_c = 32'(prescale);
      default:      rdt_c = 32'd0;
    endcase
  end

  // Handshake and read data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
      shadow   <= 32'd0;
    end else begin
      o_wb_ack <= access_c;
      if (rd_c) begin
        o_wb_rdt <= rdt_c;
        if (i_wb_adr == ADR_MTIME_LO) begin
          shadow <= mtime[63:32];
        end
      end
    end
  end

  // Counter, compare and prescale registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      mtime <= mtime_nxt_c;
      if (wr_c && i_wb_adr == ADR_CMP_LO) begin
        mtimecmp[31:0] <= lane_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
      end
      if (wr_c && i_wb_adr == ADR_CMP_HI) begin
        mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
      end
      if (wr_c && i_wb_adr == ADR_PRESCALE) begin
        prescale <= PRESCALE_W'(lane_merge(32'(prescale), i_wb_dat, i_wb_sel));
        pcnt     <= '0;
      end else if (tick_c) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESCALE_W'(1);
      end
    end
  end

  // Level interrupt, compared every cycle from current register values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_servile_timer.sv
// Directed self-checking bench for servile_timer.
module tb_servile_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  adr = 3'd0;
  logic [31:0] dat = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic        we  = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic        irq_at_ack;
  logic [31:0] r;
  int          lat;

  servile_timer #(.PRESCALE_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Called right after a negedge; returns one negedge after the ack cycle.
  task automatic xfer(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output logic [31:0] rd, output int l);
    logic got;
    got = 1'b0;
    l = 0;
    adr = a; dat = d; sel = s; we = w; stb = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      l++;
      if (ack) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL ack_timeout adr=%0d no ack within 8 cycles", a); end
    rd = rdt;
    irq_at_ack = irq;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    int unused_l;
    xfer(a, d, 4'hF, 1'b1, unused_rd, unused_l);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    int unused_l;
    xfer(a, 32'd0, 4'hF, 1'b0, v, unused_l);
  endtask

  task automatic test_reset;
    logic [31:0] exp_v [5];
    exp_v = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    #12;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
    checks++; if (rdt !== 32'd0) begin errors++; $display("FAIL rst_rdt got %h exp 0", rdt); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      xfer(3'(i), 32'd0, 4'hF, 1'b0, r, lat);
      checks++; if (r !== exp_v[i]) begin errors++; $display("FAIL rst_read%0d got %h exp %h", i, r, exp_v[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL rst_lat%0d got %0d exp 1", i, lat); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack_len%0d got %b exp 0", i, ack); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq_after got %b exp 0", irq); end
  endtask

  task automatic test_prescaler;
    wr(3'd4, 32'd3);
    wr(3'd0, 32'd0);
    repeat (40) @(negedge clk);
    rd(3'd0, r);
    checks++; if (r !== 32'd10) begin errors++; $display("FAIL presc3 got %0d exp 10", r); end
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd0);
    repeat (40) @(negedge clk);
    rd(3'd0, r);
    checks++; if (r !== 32'd41) begin errors++; $display("FAIL presc0 got %0d exp 41", r); end
  endtask

  task automatic test_write_priority;
    wr(3'd1, 32'd5);
    wr(3'd0, 32'h1234);
    rd(3'd0, r);
    checks++; if (r !== 32'h1235) begin errors++; $display("FAIL wr_prio_lo got %h exp 1235", r); end
    rd(3'd1, r);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL wr_prio_hi got %h exp 5", r); end
  endtask

  task automatic test_carry;
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFE);
    repeat (4) @(negedge clk);
    rd(3'd0, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL carry_lo got %h exp 3", r); end
    rd(3'd1, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL carry_hi got %h exp 1", r); end
  endtask

  task automatic test_shadow;
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFE);
    rd(3'd0, r);
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL shadow_lo got %h exp ffffffff", r); end
    rd(3'd1, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL shadow_hi got %h exp 0", r); end
    rd(3'd0, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL shadow_lo2 got %h exp 3", r); end
    rd(3'd1, r);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL shadow_hi2 got %h exp 1", r); end
  endtask

  task automatic test_interrupt;
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd100);
    wr(3'd3, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_armed got %b exp 0", irq); end
    repeat (95) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_at99 got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at100 got %b exp 1", irq); end
    wr(3'd2, 32'hFFFF_FFFF);
    checks++; if (irq_at_ack !== 1'b1) begin errors++; $display("FAIL irq_during_ack got %b exp 1", irq_at_ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
  endtask

  task automatic test_byte_select;
    logic [31:0] unused_rd;
    xfer(3'd2, 32'hAABB_CCDD, 4'b0101, 1'b1, unused_rd, lat);
    rd(3'd2, r);
    checks++; if (r !== 32'hFFBB_FFDD) begin errors++; $display("FAIL byte_sel got %h exp ffbbffdd", r); end
    wr(3'd6, 32'h1234_5678);
    rd(3'd6, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL adr6 got %h exp 0", r); end
    rd(3'd5, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL adr5 got %h exp 0", r); end
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, r);
    checks++; if (r !== 32'h0000_00FF) begin errors++; $display("FAIL presc_width got %h exp ff", r); end
    rd(3'd3, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL cmp_hi_kept got %h exp 0", r); end
  endtask

  task automatic test_back_to_back;
    adr = 3'd4; we = 1'b0; sel = 4'hF; stb = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", ack); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", ack); end
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got %b exp 1", ack); end
    checks++; if (rdt !== 32'h0000_00FF) begin errors++; $display("FAIL b2b_rdt got %h exp ff", rdt); end
    stb = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", ack); end
  endtask

  task automatic test_reset_mid;
    wr(3'd4, 32'd255);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd500);
    adr = 3'd0; we = 1'b0; sel = 4'hF; stb = 1'b1;
    @(posedge clk);
    #2;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack_pre got %b exp 1", ack); end
    checks++; if (rdt !== 32'd500) begin errors++; $display("FAIL mid_rdt_pre got %0d exp 500", rdt); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq_pre got %b exp 1", irq); end
    rst = 1'b1;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack_async got %b exp 0", ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_async got %b exp 0", irq); end
    checks++; if (rdt !== 32'd0) begin errors++; $display("FAIL mid_rdt_async got %h exp 0", rdt); end
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack_held got %b exp 0", ack); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack_post got %b exp 1", ack); end
    checks++; if (rdt !== 32'd0) begin errors++; $display("FAIL mid_mtime_post got %h exp 0", rdt); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq_post got %b exp 0", irq); end
    stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_prescaler;
    test_write_priority;
    test_carry;
    test_shadow;
    test_interrupt;
    test_byte_select;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
